// File: rtl/core_pkg.sv
// Shared fetch-side definitions for the RV32I core: sequencer states,
// datapath width and instruction alignment helper.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    REDIRECT,
    HALT
  } seq_state_t;

  function automatic logic is_aligned(input logic [1:0] addr_low);
    return (addr_low & INSTR_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side controller: owns the PC, issues fetch requests, applies taken
// branches with a timed IF/ID flush, traps misaligned targets.
module pc_sequencer
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            pcsrc,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_valid,
  output logic            flush,
  output logic            halted,
  output logic [15:0]     taken_cnt
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  seq_state_t      state_q;
  seq_state_t      state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [3:0]      cnt_q;
  logic [3:0]      cnt_d;
  logic            fetch_done;
  logic            taken_inc;
  logic            redirect_ok;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    imem_req    = 1'b0;
    flush       = 1'b0;
    taken_inc   = 1'b0;
    redirect_ok = 1'b0;

    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: imem_req = ~stall & ~pcsrc;
      REDIRECT: begin
        flush = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) begin
          state_d = FETCH;
        end
      end
      default: state_d = HALT;
    endcase

    fetch_done  = imem_req & imem_ready;
    fetch_valid = fetch_done & ~pcsrc;
    if (fetch_valid) begin
      pc_d = pc_q + XLEN'(4);
    end

    // A taken branch overrides everything else this cycle, including a completing fetch.
    redirect_ok = pcsrc & ((state_q == FETCH) | (state_q == REDIRECT));
    if (redirect_ok) begin
      flush = 1'b1;
      if (is_aligned(branch_target[1:0])) begin
        pc_d      = branch_target;
        cnt_d     = FLUSH_LOAD;
        taken_inc = 1'b1;
        state_d   = (FLUSH_CYCLES > 1) ? REDIRECT : FETCH;
      end else begin
        pc_d    = pc_q;
        state_d = HALT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  sat_counter #(
    .WIDTH(16)
  ) u_taken_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (taken_inc),
    .count(taken_cnt)
  );

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign pc_plus4  = pc_q + XLEN'(4);
  assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the fetch rules.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC     = 32'h0000_0100;
  localparam int          FLUSH_CYCLES = 2;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        pcsrc;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush;
  logic        halted;
  logic [15:0] taken_cnt;

  int compared;
  int mismatched;

  // Behavioural model state: boot flag, remaining flush cycles, trap flag.
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_halted;
  int          m_flush_left;
  int          m_taken;
  logic        e_req;
  logic        e_fv;
  logic        e_flush;
  logic        e_halted;

  pc_sequencer #(
    .RESET_PC    (RESET_PC),
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .pcsrc        (pcsrc),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fetch_valid  (fetch_valid),
    .flush        (flush),
    .halted       (halted),
    .taken_cnt    (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_pc         = RESET_PC;
    m_boot       = 1'b1;
    m_halted     = 1'b0;
    m_flush_left = 0;
    m_taken      = 0;
  endfunction

  function automatic void model_eval();
    e_req    = 1'b0;
    e_fv     = 1'b0;
    e_flush  = 1'b0;
    e_halted = m_halted;
    if (!m_halted && !m_boot) begin
      e_flush = pcsrc || (m_flush_left > 0);
      e_req   = (m_flush_left == 0) && !stall && !pcsrc;
      e_fv    = e_req && imem_ready;
    end
  endfunction

  function automatic void model_advance();
    if (m_halted) begin
      m_halted = 1'b1;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (pcsrc) begin
      if (branch_target[1:0] == 2'b00) begin
        m_pc         = branch_target;
        m_flush_left = FLUSH_CYCLES - 1;
        if (m_taken < 65535) m_taken = m_taken + 1;
      end else begin
        m_halted = 1'b1;
      end
    end else if (m_flush_left > 0) begin
      m_flush_left = m_flush_left - 1;
    end else if (e_fv) begin
      m_pc = m_pc + 32'd4;
    end
  endfunction

  task automatic drive(input logic s, input logic p, input logic [31:0] t, input logic r);
    stall         = s;
    pcsrc         = p;
    branch_target = t;
    imem_ready    = r;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_eval();
    model_advance();
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] t);
    drive(1'b0, 1'b1, t, 1'b1);
    tick();
    repeat (FLUSH_CYCLES - 1) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    model_reset();
    @(posedge clk);
    #1;
    @(negedge clk);
    compared += 6;
    if (pc !== 32'h100) begin mismatched++; $display("[TB] FAIL rst_pc: got %h expected %h", pc, 32'h100); end
    if (imem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_req: got %b expected 0", imem_req); end
    if (fetch_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_fv: got %b expected 0", fetch_valid); end
    if (flush !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_flush: got %b expected 0", flush); end
    if (halted !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_halted: got %b expected 0", halted); end
    if (taken_cnt !== 16'h0) begin mismatched++; $display("[TB] FAIL rst_taken: got %h expected 0", taken_cnt); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    compared++;
    if (imem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL boot_req: got %b expected 0", imem_req); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    compared += 3;
    if (imem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL first_req: got %b expected 1", imem_req); end
    if (imem_addr !== 32'h100) begin mismatched++; $display("[TB] FAIL first_addr: got %h expected %h", imem_addr, 32'h100); end
    if (fetch_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL first_fv: got %b expected 1", fetch_valid); end
    for (int i = 1; i <= 2; i++) begin
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      compared += 2;
      if (pc !== 32'h100 + 32'(4 * i)) begin mismatched++; $display("[TB] FAIL seq_pc: got %h expected %h", pc, 32'h100 + 32'(4 * i)); end
      if (fetch_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL seq_fv: got %b expected 1", fetch_valid); end
    end
    tick();
  endtask

  task automatic test_mem_wait();
    redirect_to(32'h200);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      compared += 3;
      if (imem_addr !== 32'h200) begin mismatched++; $display("[TB] FAIL wait_addr: got %h expected %h", imem_addr, 32'h200); end
      if (imem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL wait_req: got %b expected 1", imem_req); end
      if (fetch_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL wait_fv: got %b expected 0", fetch_valid); end
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    compared++;
    if (fetch_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL ready_fv: got %b expected 1", fetch_valid); end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      compared += 3;
      if (imem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_req: got %b expected 0", imem_req); end
      if (fetch_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_fv: got %b expected 0", fetch_valid); end
      if (pc !== 32'h204) begin mismatched++; $display("[TB] FAIL stall_pc: got %h expected %h", pc, 32'h204); end
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    compared++;
    if (imem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL unstall_req: got %b expected 1", imem_req); end
    tick();
  endtask

  task automatic test_branch();
    int prev;
    redirect_to(32'h300);
    prev = m_taken;
    drive(1'b0, 1'b1, 32'h400, 1'b1);
    @(negedge clk);
    compared += 2;
    if (fetch_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL br_fv: got %b expected 0", fetch_valid); end
    if (flush !== 1'b1) begin mismatched++; $display("[TB] FAIL br_flush0: got %b expected 1", flush); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    compared += 2;
    if (flush !== 1'b1) begin mismatched++; $display("[TB] FAIL br_flush1: got %b expected 1", flush); end
    if (imem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL br_req1: got %b expected 0", imem_req); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    compared += 4;
    if (flush !== 1'b0) begin mismatched++; $display("[TB] FAIL br_flush2: got %b expected 0", flush); end
    if (imem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL br_req2: got %b expected 1", imem_req); end
    if (imem_addr !== 32'h400) begin mismatched++; $display("[TB] FAIL br_addr: got %h expected %h", imem_addr, 32'h400); end
    if (taken_cnt !== 16'(prev + 1)) begin mismatched++; $display("[TB] FAIL br_taken: got %0d expected %0d", taken_cnt, prev + 1); end
    tick();
  endtask

  task automatic test_back_to_back();
    int prev;
    prev = m_taken;
    drive(1'b0, 1'b1, 32'h400, 1'b1);
    tick();
    drive(1'b0, 1'b1, 32'h500, 1'b1);
    @(negedge clk);
    compared += 2;
    if (flush !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_flush0: got %b expected 1", flush); end
    if (imem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_req0: got %b expected 0", imem_req); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    compared++;
    if (flush !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_flush1: got %b expected 1", flush); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    compared += 4;
    if (flush !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_flush2: got %b expected 0", flush); end
    if (imem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_req: got %b expected 1", imem_req); end
    if (imem_addr !== 32'h500) begin mismatched++; $display("[TB] FAIL b2b_addr: got %h expected %h", imem_addr, 32'h500); end
    if (taken_cnt !== 16'(prev + 2)) begin mismatched++; $display("[TB] FAIL b2b_taken: got %0d expected %0d", taken_cnt, prev + 2); end
    tick();
  endtask

  task automatic test_misaligned();
    logic [31:0] held_pc;
    int          prev;
    held_pc = m_pc;
    prev    = m_taken;
    drive(1'b0, 1'b1, 32'h402, 1'b1);
    @(negedge clk);
    compared += 2;
    if (fetch_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mis_fv: got %b expected 0", fetch_valid); end
    if (flush !== 1'b1) begin mismatched++; $display("[TB] FAIL mis_flush: got %b expected 1", flush); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    compared += 4;
    if (halted !== 1'b1) begin mismatched++; $display("[TB] FAIL mis_halted: got %b expected 1", halted); end
    if (imem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL mis_req: got %b expected 0", imem_req); end
    if (pc !== held_pc) begin mismatched++; $display("[TB] FAIL mis_pc: got %h expected %h", pc, held_pc); end
    if (flush !== 1'b0) begin mismatched++; $display("[TB] FAIL mis_hflush: got %b expected 0", flush); end
    tick();
    drive(1'b0, 1'b1, 32'h600, 1'b1);
    @(negedge clk);
    compared++;
    if (flush !== 1'b0) begin mismatched++; $display("[TB] FAIL halt_ign_flush: got %b expected 0", flush); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    compared += 3;
    if (pc !== held_pc) begin mismatched++; $display("[TB] FAIL halt_ign_pc: got %h expected %h", pc, held_pc); end
    if (halted !== 1'b1) begin mismatched++; $display("[TB] FAIL halt_stay: got %b expected 1", halted); end
    if (taken_cnt !== 16'(prev)) begin mismatched++; $display("[TB] FAIL halt_taken: got %0d expected %0d", taken_cnt, prev); end
    rst_n = 1'b0;
    #1;
    model_reset();
    compared += 4;
    if (halted !== 1'b0) begin mismatched++; $display("[TB] FAIL arst_halted: got %b expected 0", halted); end
    if (pc !== RESET_PC) begin mismatched++; $display("[TB] FAIL arst_pc: got %h expected %h", pc, RESET_PC); end
    if (imem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL arst_req: got %b expected 0", imem_req); end
    if (taken_cnt !== 16'h0) begin mismatched++; $display("[TB] FAIL arst_taken: got %h expected 0", taken_cnt); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] t;
    logic        s;
    logic        p;
    logic        r;
    for (int i = 0; i < 400; i++) begin
      t = {$urandom(), 2'b00} >> 2;
      t = {t[29:0], 2'b00};
      s = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 2) != 0);
      drive(s, p, t, r);
      @(negedge clk);
      compared += 7;
      if (imem_req !== e_req) begin mismatched++; $display("[TB] FAIL rnd_req: got %b expected %b", imem_req, e_req); end
      if (fetch_valid !== e_fv) begin mismatched++; $display("[TB] FAIL rnd_fv: got %b expected %b", fetch_valid, e_fv); end
      if (flush !== e_flush) begin mismatched++; $display("[TB] FAIL rnd_flush: got %b expected %b", flush, e_flush); end
      if (halted !== e_halted) begin mismatched++; $display("[TB] FAIL rnd_halted: got %b expected %b", halted, e_halted); end
      if (imem_addr !== m_pc) begin mismatched++; $display("[TB] FAIL rnd_addr: got %h expected %h", imem_addr, m_pc); end
      if (pc_plus4 !== m_pc + 32'd4) begin mismatched++; $display("[TB] FAIL rnd_pc4: got %h expected %h", pc_plus4, m_pc + 32'd4); end
      if (taken_cnt !== 16'(m_taken)) begin mismatched++; $display("[TB] FAIL rnd_taken: got %0d expected %0d", taken_cnt, m_taken); end
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (FLUSH_CYCLES) tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 65540; i++) begin
      drive(1'b0, 1'b1, 32'h700, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    compared += 2;
    if (taken_cnt !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL sat_taken: got %h expected FFFF", taken_cnt); end
    if (taken_cnt !== 16'(m_taken)) begin mismatched++; $display("[TB] FAIL sat_model: got %h expected %h", taken_cnt, 16'(m_taken)); end
    tick();
  endtask

  task automatic test_wrap();
    redirect_to(32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    compared += 3;
    if (pc !== 32'hFFFF_FFFC) begin mismatched++; $display("[TB] FAIL wrap_pc0: got %h expected FFFFFFFC", pc); end
    if (pc_plus4 !== 32'h0) begin mismatched++; $display("[TB] FAIL wrap_pc4: got %h expected 0", pc_plus4); end
    if (fetch_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_fv: got %b expected 1", fetch_valid); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    compared++;
    if (pc !== 32'h0) begin mismatched++; $display("[TB] FAIL wrap_pc1: got %h expected 0", pc); end
    tick();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_mem_wait();
    test_branch();
    test_back_to_back();
    test_misaligned();
    test_random();
    test_saturation();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
